// File: rtl/tx_huge_page_sched_pkg.sv
// Shared types and constants for the TX huge-page scheduler.
package tx_huge_page_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_NOTIFY,
    ST_RELEASE
  } state_e;

  localparam logic        PAGE_1        = 1'b0;
  localparam logic        PAGE_2        = 1'b1;
  localparam logic [12:0] PAGE_4K_BYTES = 13'd4096;

  // Completion word: sequence number above, page index in bit 0.
  function automatic logic [31:0] cpl_word(input logic [30:0] seq, input logic page_idx);
    return {seq, page_idx};
  endfunction

endpackage

// File: rtl/tx_rd_chunker.sv
// Picks the next read length: min(remaining, MAX_RD_QWORDS, qwords left in this 4 KB page).
module tx_rd_chunker
  import tx_huge_page_sched_pkg::*;
#(
  parameter int MAX_RD_QWORDS = 64
) (
  input  logic [11:0] page_off,
  input  logic [31:0] remaining,
  output logic [9:0]  chunk
);

  logic [12:0] bytes_to_4k;
  logic [9:0]  qw_to_4k;
  logic [9:0]  rem_sat;
  logic [9:0]  lim;

  always_comb begin
    // page_off is qword aligned, so the shift is exact; range is 1..512
    bytes_to_4k = PAGE_4K_BYTES - {1'b0, page_off};
    qw_to_4k    = 10'(bytes_to_4k >> 3);
    rem_sat     = (remaining > 32'd512) ? 10'd512 : remaining[9:0];
    lim         = 10'(MAX_RD_QWORDS);
    if (qw_to_4k < lim) lim = qw_to_4k;
    if (rem_sat < lim)  lim = rem_sat;
    chunk = lim;
  end

endmodule

// File: rtl/tx_huge_page_sched.sv
// Ping-pongs the two TX huge pages: splits each into DMA reads, posts a completion, frees the page.
module tx_huge_page_sched
  import tx_huge_page_sched_pkg::*;
#(
  parameter int MAX_RD_QWORDS   = 64,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        trn_clk,
  input  logic        reset,
  input  logic [63:0] huge_page_addr_1,
  input  logic [63:0] huge_page_addr_2,
  input  logic [31:0] huge_page_qwords_1,
  input  logic [31:0] huge_page_qwords_2,
  input  logic        huge_page_status_1,
  input  logic        huge_page_status_2,
  output logic        huge_page_free_1,
  output logic        huge_page_free_2,
  input  logic [63:0] completed_buffer_address,
  output logic        rd_req_valid,
  input  logic        rd_req_ready,
  output logic [63:0] rd_req_addr,
  output logic [9:0]  rd_req_qwords,
  input  logic        rd_done,
  output logic        cpl_wr_valid,
  input  logic        cpl_wr_ready,
  output logic [63:0] cpl_wr_addr,
  output logic [31:0] cpl_wr_data
);

  state_e      state, state_nxt;
  logic        cur_page;
  logic [30:0] seq;
  logic [3:0]  outstanding;
  logic [63:0] next_addr;
  logic [31:0] remaining;
  logic [9:0]  chunk;

  logic        cur_status;
  logic [63:0] cur_addr;
  logic [31:0] cur_qwords;
  logic        rd_accept, cpl_accept, done_eff, can_issue;

  assign cur_status = (cur_page == PAGE_2) ? huge_page_status_2 : huge_page_status_1;
  assign cur_addr   = (cur_page == PAGE_2) ? huge_page_addr_2   : huge_page_addr_1;
  assign cur_qwords = (cur_page == PAGE_2) ? huge_page_qwords_2 : huge_page_qwords_1;
  assign rd_accept  = rd_req_valid & rd_req_ready;
  assign cpl_accept = cpl_wr_valid & cpl_wr_ready;
  assign done_eff   = rd_done & (outstanding != 4'd0);
  assign can_issue  = (state == ST_ISSUE) && !rd_req_valid && (remaining != 32'd0) &&
                      (outstanding < 4'(MAX_OUTSTANDING));

  tx_rd_chunker #(.MAX_RD_QWORDS(MAX_RD_QWORDS)) u_chunker (
    .page_off  (next_addr[11:0]),
    .remaining (remaining),
    .chunk     (chunk)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cur_status) state_nxt = ST_LOAD;
      ST_LOAD:    state_nxt = (cur_qwords == 32'd0) ? ST_NOTIFY : ST_ISSUE;
      ST_ISSUE:   if (remaining == 32'd0 && !rd_req_valid) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (outstanding == 4'd0) state_nxt = ST_NOTIFY;
      ST_NOTIFY:  if (cpl_accept) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge trn_clk or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      cur_page         <= PAGE_1;
      seq              <= '0;
      outstanding      <= '0;
      next_addr        <= '0;
      remaining        <= '0;
      rd_req_valid     <= 1'b0;
      rd_req_addr      <= '0;
      rd_req_qwords    <= '0;
      cpl_wr_valid     <= 1'b0;
      cpl_wr_addr      <= '0;
      cpl_wr_data      <= '0;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == ST_LOAD) begin
        next_addr <= {cur_addr[63:3], 3'b000};
        remaining <= cur_qwords;
      end else if (rd_accept) begin
        next_addr <= next_addr + {51'd0, rd_req_qwords, 3'b000};
        remaining <= remaining - {22'd0, rd_req_qwords};
      end

      if (rd_accept && !done_eff)      outstanding <= outstanding + 4'd1;
      else if (!rd_accept && done_eff) outstanding <= outstanding - 4'd1;

      // Request is decided one cycle after the previous accept so counters are settled.
      if (rd_accept) begin
        rd_req_valid <= 1'b0;
      end else if (can_issue) begin
        rd_req_valid  <= 1'b1;
        rd_req_addr   <= next_addr;
        rd_req_qwords <= chunk;
      end

      if (state != ST_NOTIFY && state_nxt == ST_NOTIFY) begin
        cpl_wr_valid <= 1'b1;
        cpl_wr_addr  <= completed_buffer_address;
        cpl_wr_data  <= cpl_word(seq, cur_page);
      end else if (cpl_accept) begin
        cpl_wr_valid <= 1'b0;
      end

      huge_page_free_1 <= (state == ST_NOTIFY) && cpl_accept && (cur_page == PAGE_1);
      huge_page_free_2 <= (state == ST_NOTIFY) && cpl_accept && (cur_page == PAGE_2);

      if (state == ST_RELEASE) begin
        seq      <= seq + 31'd1;
        cur_page <= ~cur_page;
      end
    end
  end

endmodule
